proc_hier: RTL and testbench

- Processor-hierarchy shell that sits between the pipelined 16-bit core and the simulation/debug environment.
- Samples the core's per-cycle commit signals (PC, instruction, register write, memory access, halt, cache events) and republishes them as a one-cycle-registered trace.
- Keeps cycle, instruction and cache performance counters.
- Freezes all activity once a halt commits.

---
 rtl/proc_hier_pkg.sv | 15 +
 rtl/proc_hier_sat_cnt.sv | 30 +++
 rtl/proc_hier.sv | 184 ++++++++++++++++++
 tb/tb_proc_hier.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/proc_hier_pkg.sv
// Shared defaults, trace-kind bit positions and types for the proc_hier trace/statistics shell.
package proc_hier_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_REG_AW = 3;
    localparam int unsigned DEF_CNT_W  = 32;

    localparam int unsigned KIND_REGWR = 0;
    localparam int unsigned KIND_MEMRD = 1;
    localparam int unsigned KIND_MEMWR = 2;
    localparam int unsigned KIND_HALT  = 3;

    typedef logic [3:0] trace_kind_t;

endpackage

// File: rtl/proc_hier_sat_cnt.sv
// Enable-gated up-counter that sticks at all-ones, with asynchronous active-low clear.
module proc_hier_sat_cnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/proc_hier.sv
// Core commit-trace republisher with performance counters and halt freeze.
// Cache statistics counters are built only when PROC_HIER_CACHE_STATS_EN is defined.
module proc_hier
    import proc_hier_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned REG_AW = DEF_REG_AW,
    parameter int unsigned CNT_W  = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] inst_i,
    input  logic              reg_wr_i,
    input  logic [REG_AW-1:0] wr_reg_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              mem_rd_i,
    input  logic              mem_wr_i,
    input  logic [DATA_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              halt_i,
    input  logic              icache_req_i,
    input  logic              icache_hit_i,
    input  logic              dcache_req_i,
    input  logic              dcache_hit_i,
    output logic              trace_valid_o,
    output logic [3:0]        trace_kind_o,
    output logic [DATA_W-1:0] trace_pc_o,
    output logic [DATA_W-1:0] trace_inst_o,
    output logic [DATA_W-1:0] trace_wdata_o,
    output logic [DATA_W-1:0] trace_addr_o,
    output logic [DATA_W-1:0] trace_mwdata_o,
    output logic [DATA_W-1:0] trace_mrdata_o,
    output logic [REG_AW-1:0] trace_reg_o,
    output logic [CNT_W-1:0]  cycle_count_o,
    output logic [CNT_W-1:0]  inst_count_o,
    output logic [CNT_W-1:0]  icache_req_cnt_o,
    output logic [CNT_W-1:0]  icache_hit_cnt_o,
    output logic [CNT_W-1:0]  dcache_req_cnt_o,
    output logic [CNT_W-1:0]  dcache_hit_cnt_o,
    output logic              halted_o,
    output logic              err_o
);

    logic              active;
    logic              halted_q, halted_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    trace_kind_t       kind_q, kind_d;
    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] mwdata_q, mwdata_d;
    logic [DATA_W-1:0] mrdata_q, mrdata_d;
    logic [REG_AW-1:0] reg_q, reg_d;

    assign active = ~halted_q;

    always_comb begin
        halted_d = halted_q;
        err_d    = err_q;
        valid_d  = 1'b0;
        kind_d   = kind_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        wdata_d  = wdata_q;
        addr_d   = addr_q;
        mwdata_d = mwdata_q;
        mrdata_d = mrdata_q;
        reg_d    = reg_q;
        if (active) begin
            halted_d             = halt_i;
            err_d                = err_q | (mem_rd_i & mem_wr_i);
            valid_d              = reg_wr_i | mem_rd_i | mem_wr_i | halt_i;
            kind_d               = '0;
            kind_d[KIND_REGWR]   = reg_wr_i;
            kind_d[KIND_MEMRD]   = mem_rd_i;
            kind_d[KIND_MEMWR]   = mem_wr_i;
            kind_d[KIND_HALT]    = halt_i;
            pc_d                 = pc_i;
            inst_d               = inst_i;
            wdata_d              = wr_data_i;
            addr_d               = mem_addr_i;
            mwdata_d             = mem_wdata_i;
            mrdata_d             = mem_rdata_i;
            reg_d                = wr_reg_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
            kind_q   <= '0;
            pc_q     <= '0;
            inst_q   <= '0;
            wdata_q  <= '0;
            addr_q   <= '0;
            mwdata_q <= '0;
            mrdata_q <= '0;
            reg_q    <= '0;
        end else begin
            halted_q <= halted_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
            kind_q   <= kind_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            wdata_q  <= wdata_d;
            addr_q   <= addr_d;
            mwdata_q <= mwdata_d;
            mrdata_q <= mrdata_d;
            reg_q    <= reg_d;
        end
    end

    proc_hier_sat_cnt #(.W(CNT_W)) u_cycle_cnt (
        .clk_i (clk),
        .rst_ni(rst),
        .en_i  (active),
        .cnt_o (cycle_count_o)
    );

    proc_hier_sat_cnt #(.W(CNT_W)) u_inst_cnt (
        .clk_i (clk),
        .rst_ni(rst),
        .en_i  (active & (halt_i | reg_wr_i | mem_wr_i)),
        .cnt_o (inst_count_o)
    );

`ifdef PROC_HIER_CACHE_STATS_EN
    // A hit only counts when it accompanies a request.
    proc_hier_sat_cnt #(.W(CNT_W)) u_icache_req_cnt (
        .clk_i (clk),
        .rst_ni(rst),
        .en_i  (active & icache_req_i),
        .cnt_o (icache_req_cnt_o)
    );

    proc_hier_sat_cnt #(.W(CNT_W)) u_icache_hit_cnt (
        .clk_i (clk),
        .rst_ni(rst),
        .en_i  (active & icache_req_i & icache_hit_i),
        .cnt_o (icache_hit_cnt_o)
    );

    proc_hier_sat_cnt #(.W(CNT_W)) u_dcache_req_cnt (
        .clk_i (clk),
        .rst_ni(rst),
        .en_i  (active & dcache_req_i),
        .cnt_o (dcache_req_cnt_o)
    );

    proc_hier_sat_cnt #(.W(CNT_W)) u_dcache_hit_cnt (
        .clk_i (clk),
        .rst_ni(rst),
        .en_i  (active & dcache_req_i & dcache_hit_i),
        .cnt_o (dcache_hit_cnt_o)
    );
`else
    logic unused_cache;
    assign unused_cache     = ^{icache_req_i, icache_hit_i, dcache_req_i, dcache_hit_i};
    assign icache_req_cnt_o = '0;
    assign icache_hit_cnt_o = '0;
    assign dcache_req_cnt_o = '0;
    assign dcache_hit_cnt_o = '0;
`endif

    assign trace_valid_o  = valid_q;
    assign trace_kind_o   = kind_q;
    assign trace_pc_o     = pc_q;
    assign trace_inst_o   = inst_q;
    assign trace_wdata_o  = wdata_q;
    assign trace_addr_o   = addr_q;
    assign trace_mwdata_o = mwdata_q;
    assign trace_mrdata_o = mrdata_q;
    assign trace_reg_o    = reg_q;
    assign halted_o       = halted_q;
    assign err_o          = err_q;

endmodule

// File: tb/tb_proc_hier.sv
// Directed bench for proc_hier: trace, counters, error, halt freeze and 4-bit counter saturation.
module tb_proc_hier;

    localparam int unsigned DW = 16;
    localparam int unsigned RW = 3;
    localparam int unsigned CW = 32;
    localparam int unsigned SW = 4;

    logic clk = 1'b0;
    logic rst;
    logic [DW-1:0] pc_i, inst_i, wr_data_i, mem_addr_i, mem_wdata_i, mem_rdata_i;
    logic [RW-1:0] wr_reg_i;
    logic reg_wr_i, mem_rd_i, mem_wr_i, halt_i;
    logic icache_req_i, icache_hit_i, dcache_req_i, dcache_hit_i;

    logic          trace_valid_o, halted_o, err_o;
    logic [3:0]    trace_kind_o;
    logic [DW-1:0] trace_pc_o, trace_inst_o, trace_wdata_o, trace_addr_o, trace_mwdata_o, trace_mrdata_o;
    logic [RW-1:0] trace_reg_o;
    logic [CW-1:0] cycle_count_o, inst_count_o;
    logic [CW-1:0] icache_req_cnt_o, icache_hit_cnt_o, dcache_req_cnt_o, dcache_hit_cnt_o;

    logic          s_valid, s_halted, s_err;
    logic [3:0]    s_kind;
    logic [DW-1:0] s_pc, s_inst, s_wdata, s_addr, s_mwdata, s_mrdata;
    logic [RW-1:0] s_reg;
    logic [SW-1:0] s_cycle, s_icnt, s_irq, s_ihit, s_drq, s_dhit;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    always #5 clk = ~clk;

    proc_hier #(.DATA_W(DW), .REG_AW(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .pc_i(pc_i), .inst_i(inst_i), .reg_wr_i(reg_wr_i), .wr_reg_i(wr_reg_i),
        .wr_data_i(wr_data_i), .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_i(mem_rdata_i),
        .halt_i(halt_i), .icache_req_i(icache_req_i), .icache_hit_i(icache_hit_i),
        .dcache_req_i(dcache_req_i), .dcache_hit_i(dcache_hit_i),
        .trace_valid_o(trace_valid_o), .trace_kind_o(trace_kind_o),
        .trace_pc_o(trace_pc_o), .trace_inst_o(trace_inst_o), .trace_wdata_o(trace_wdata_o),
        .trace_addr_o(trace_addr_o), .trace_mwdata_o(trace_mwdata_o),
        .trace_mrdata_o(trace_mrdata_o), .trace_reg_o(trace_reg_o),
        .cycle_count_o(cycle_count_o), .inst_count_o(inst_count_o),
        .icache_req_cnt_o(icache_req_cnt_o), .icache_hit_cnt_o(icache_hit_cnt_o),
        .dcache_req_cnt_o(dcache_req_cnt_o), .dcache_hit_cnt_o(dcache_hit_cnt_o),
        .halted_o(halted_o), .err_o(err_o)
    );

    proc_hier #(.DATA_W(DW), .REG_AW(RW), .CNT_W(SW)) dut_sat (
        .clk(clk), .rst(rst),
        .pc_i(pc_i), .inst_i(inst_i), .reg_wr_i(reg_wr_i), .wr_reg_i(wr_reg_i),
        .wr_data_i(wr_data_i), .mem_rd_i(mem_rd_i), .mem_wr_i(mem_wr_i),
        .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_rdata_i(mem_rdata_i),
        .halt_i(halt_i), .icache_req_i(icache_req_i), .icache_hit_i(icache_hit_i),
        .dcache_req_i(dcache_req_i), .dcache_hit_i(dcache_hit_i),
        .trace_valid_o(s_valid), .trace_kind_o(s_kind),
        .trace_pc_o(s_pc), .trace_inst_o(s_inst), .trace_wdata_o(s_wdata),
        .trace_addr_o(s_addr), .trace_mwdata_o(s_mwdata),
        .trace_mrdata_o(s_mrdata), .trace_reg_o(s_reg),
        .cycle_count_o(s_cycle), .inst_count_o(s_icnt),
        .icache_req_cnt_o(s_irq), .icache_hit_cnt_o(s_ihit),
        .dcache_req_cnt_o(s_drq), .dcache_hit_cnt_o(s_dhit),
        .halted_o(s_halted), .err_o(s_err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        pc_i = '0; inst_i = '0; wr_data_i = '0; mem_addr_i = '0;
        mem_wdata_i = '0; mem_rdata_i = '0; wr_reg_i = '0;
        reg_wr_i = 1'b0; mem_rd_i = 1'b0; mem_wr_i = 1'b0; halt_i = 1'b0;
        icache_req_i = 1'b0; icache_hit_i = 1'b0; dcache_req_i = 1'b0; dcache_hit_i = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_valid"},  64'(trace_valid_o), 64'd0);
        check({tag, "_kind"},   64'(trace_kind_o),  64'd0);
        check({tag, "_pc"},     64'(trace_pc_o),    64'd0);
        check({tag, "_addr"},   64'(trace_addr_o),  64'd0);
        check({tag, "_cycle"},  64'(cycle_count_o), 64'd0);
        check({tag, "_inst"},   64'(inst_count_o),  64'd0);
        check({tag, "_icreq"},  64'(icache_req_cnt_o), 64'd0);
        check({tag, "_halted"}, 64'(halted_o),      64'd0);
        check({tag, "_err"},    64'(err_o),         64'd0);
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        // Inputs churn while reset is held.
        for (int unsigned i = 0; i < 4; i++) begin
            pc_i = DW'($urandom); inst_i = DW'($urandom); mem_addr_i = DW'($urandom);
            reg_wr_i = 1'b1; mem_rd_i = 1'b1; mem_wr_i = 1'b1; halt_i = 1'b1;
            icache_req_i = 1'b1; icache_hit_i = 1'b1;
            tick();
        end
        check_cleared("rst_hold");

        idle_inputs();
        rst = 1'b1;
        ticks(5);
        check("idle_cycle", 64'(cycle_count_o), 64'd5);
        check("idle_inst",  64'(inst_count_o),  64'd0);
        check("idle_valid", 64'(trace_valid_o), 64'd0);

        reg_wr_i = 1'b1; wr_reg_i = 3'd3; wr_data_i = 16'h1234; pc_i = 16'h0010; inst_i = 16'hA5C3;
        tick();
        check("rw_valid", 64'(trace_valid_o), 64'd1);
        check("rw_kind",  64'(trace_kind_o),  64'h1);
        check("rw_reg",   64'(trace_reg_o),   64'd3);
        check("rw_wdata", 64'(trace_wdata_o), 64'h1234);
        check("rw_pc",    64'(trace_pc_o),    64'h0010);
        check("rw_inst",  64'(trace_inst_o),  64'hA5C3);
        check("rw_icnt",  64'(inst_count_o),  64'd1);

        idle_inputs();
        mem_rd_i = 1'b1; mem_addr_i = 16'h0040; mem_rdata_i = 16'hBEEF;
        tick();
        check("ld_kind",  64'(trace_kind_o),   64'h2);
        check("ld_valid", 64'(trace_valid_o),  64'd1);
        check("ld_addr",  64'(trace_addr_o),   64'h0040);
        check("ld_rdata", 64'(trace_mrdata_o), 64'hBEEF);
        check("ld_icnt",  64'(inst_count_o),   64'd1);

        idle_inputs();
        mem_wr_i = 1'b1; mem_addr_i = 16'h0042; mem_wdata_i = 16'h00FF;
        tick();
        check("st_kind",  64'(trace_kind_o),   64'h4);
        check("st_addr",  64'(trace_addr_o),   64'h0042);
        check("st_wdata", 64'(trace_mwdata_o), 64'h00FF);
        check("st_icnt",  64'(inst_count_o),   64'd2);
        check("st_err",   64'(err_o),          64'd0);

        idle_inputs();
        tick();
        check("gap_valid", 64'(trace_valid_o), 64'd0);
        check("gap_kind",  64'(trace_kind_o),  64'h0);

        mem_rd_i = 1'b1; mem_wr_i = 1'b1; mem_addr_i = 16'h0050;
        tick();
        check("rdwr_err",  64'(err_o),         64'd1);
        check("rdwr_kind", 64'(trace_kind_o),  64'h6);
        check("rdwr_icnt", 64'(inst_count_o),  64'd3);
        idle_inputs();
        tick();
        check("err_sticky", 64'(err_o),         64'd1);
        check("seq_cycle",  64'(cycle_count_o), 64'd11);

        // 10 icache requests (first 7 hit) then 2 hits without request.
        for (int unsigned i = 0; i < 12; i++) begin
            icache_req_i = (i < 10);
            icache_hit_i = (i < 7) || (i >= 10);
            dcache_req_i = (i < 4);
            dcache_hit_i = (i % 2 == 0);
            tick();
        end
        idle_inputs();
        check("cache_cycle", 64'(cycle_count_o), 64'd23);
        check("cache_icnt",  64'(inst_count_o),  64'd3);
`ifdef PROC_HIER_CACHE_STATS_EN
        check("ic_req", 64'(icache_req_cnt_o), 64'd10);
        check("ic_hit", 64'(icache_hit_cnt_o), 64'd7);
        check("dc_req", 64'(dcache_req_cnt_o), 64'd4);
        check("dc_hit", 64'(dcache_hit_cnt_o), 64'd2);
`else
        check("ic_req", 64'(icache_req_cnt_o), 64'd0);
        check("ic_hit", 64'(icache_hit_cnt_o), 64'd0);
        check("dc_req", 64'(dcache_req_cnt_o), 64'd0);
        check("dc_hit", 64'(dcache_hit_cnt_o), 64'd0);
`endif

        // Reset asserted between edges must clear without waiting for a clock.
        rst = 1'b0;
        #2;
        check_cleared("rst_async");
        tick();
        check("rst_edge_cycle", 64'(cycle_count_o), 64'd0);
        rst = 1'b1;
        ticks(19);
        halt_i = 1'b1; reg_wr_i = 1'b1; wr_reg_i = 3'd5; pc_i = 16'h0ABC;
        tick();
        check("halt_flag",  64'(halted_o),      64'd1);
        check("halt_cycle", 64'(cycle_count_o), 64'd20);
        check("halt_icnt",  64'(inst_count_o),  64'd1);
        check("halt_valid", 64'(trace_valid_o), 64'd1);
        check("halt_kind",  64'(trace_kind_o),  64'h9);

        halt_i = 1'b0; reg_wr_i = 1'b1; pc_i = 16'h1111;
        icache_req_i = 1'b1; icache_hit_i = 1'b1; dcache_req_i = 1'b1; dcache_hit_i = 1'b1;
        ticks(5);
        halt_i = 1'b1; mem_wr_i = 1'b1; mem_rd_i = 1'b1;
        tick();
        check("frz_cycle",  64'(cycle_count_o),    64'd20);
        check("frz_icnt",   64'(inst_count_o),     64'd1);
        check("frz_valid",  64'(trace_valid_o),    64'd0);
        check("frz_kind",   64'(trace_kind_o),     64'h9);
        check("frz_pc",     64'(trace_pc_o),       64'h0ABC);
        check("frz_reg",    64'(trace_reg_o),      64'd5);
        check("frz_icreq",  64'(icache_req_cnt_o), 64'd0);
        check("frz_err",    64'(err_o),            64'd0);
        check("frz_halted", 64'(halted_o),         64'd1);

        idle_inputs();
        rst = 1'b0;
        tick();
        check_cleared("rst_pulse");
        rst = 1'b1;
        ticks(20);
        check("sat_main_cycle", 64'(cycle_count_o), 64'd20);
        check("sat_cycle",      64'(s_cycle),       64'd15);
        tick();
        check("sat_hold",       64'(s_cycle),       64'd15);
        check("sat_main_next",  64'(cycle_count_o), 64'd21);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
